// File: rtl/sequential_subtractor_4b_slice.sv
// Multi-cycle subtractor: a - b - borrow, one 4-bit lookahead slice per cycle.
// Optional signed overflow output enabled by defining SUB_SEQ_OVERFLOW_EN.
module sequential_subtractor_4b_slice #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
`ifdef SUB_SEQ_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, bout_q;
  logic [3:0]       a_s, b_s, g, p, sum;
  logic [4:0]       c;
  logic             accept, last;

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign diff_o   = diff_q;
  assign borrow_o = bout_q;
  assign accept   = valid_i & ready_o;
  assign last     = (cnt_q == CW'(NSLICE - 1));
  assign a_s      = a_q[{cnt_q, 2'b00} +: 4];
  assign b_s      = b_q[{cnt_q, 2'b00} +: 4];

  // a - b - brw == a + ~b + ~brw; carry out is the inverted borrow
  always_comb begin
    g    = a_s & ~b_s;
    p    = a_s ^ ~b_s;
    c    = '0;
    c[0] = ~brw_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_i) state_d = RUN;
      RUN:     if (last)    state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= minuend_i;
      b_q   <= subtrahend_i;
      brw_q <= borrow_i;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      diff_q[{cnt_q, 2'b00} +: 4] <= sum;
      brw_q <= ~c[4];
      if (last) begin
        cnt_q  <= '0;
        bout_q <= ~c[4];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef SUB_SEQ_OVERFLOW_EN
  logic ovf_q;

  assign overflow_o = ovf_q;

  // on the top slice a_s/b_s/sum hold the operand and result sign bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (!accept && state_q == RUN && last) begin
      ovf_q <= (a_s[3] != b_s[3]) && (sum[3] != a_s[3]);
    end
  end
`endif

endmodule

// File: tb/tb_sequential_subtractor_4b_slice.sv
// Bench for sequential_subtractor_4b_slice: vector table, random ops,
// DONE back-pressure hold and mid-RUN reset abort, scoreboard-checked.
module tb_sequential_subtractor_4b_slice;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         valid_i, ready_o, borrow_i;
  logic         valid_o, ready_i, borrow_o;
  logic [W-1:0] minuend_i, subtrahend_i, diff_o;
`ifdef SUB_SEQ_OVERFLOW_EN
  logic         overflow_o;
`endif

  always #5 clk = ~clk;

  sequential_subtractor_4b_slice #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .minuend_i    (minuend_i),
    .subtrahend_i (subtrahend_i),
    .borrow_i     (borrow_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .diff_o       (diff_o),
    .borrow_o     (borrow_o)
`ifdef SUB_SEQ_OVERFLOW_EN
    ,
    .overflow_o   (overflow_o)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] d,
                              input logic bo, input logic ov);
    exp_t e;
    e.d  = d;
    e.bo = bo;
    e.ov = ov;
    return e;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic bin);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    return mk(r[W-1:0], r[W],
              (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input exp_t e);
    minuend_i    = a;
    subtrahend_i = b;
    borrow_i     = bin;
    valid_i      = 1'b1;
    chk("ready_before_accept", ready_o, 1);
    tick;
    sb.push_back(e);
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!valid_o && n < 20) begin
      tick;
      n++;
    end
    chk({nm, "_latency"}, n, NS);
  endtask

  task automatic consume(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty expected entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_valid"}, valid_o, 1);
      chk({nm, "_diff"}, diff_o, e.d);
      chk({nm, "_borrow"}, borrow_o, e.bo);
`ifdef SUB_SEQ_OVERFLOW_EN
      chk({nm, "_overflow"}, overflow_o, e.ov);
`endif
    end
    ready_i = 1'b1;
    tick;
    chk({nm, "_valid_drop"}, valid_o, 0);
    chk({nm, "_ready_back"}, ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           seen;

    vt[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[5] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1};
    vt[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

    rst_ni       = 1'b0;
    valid_i      = 1'b0;
    ready_i      = 1'b1;
    borrow_i     = 1'b0;
    minuend_i    = '0;
    subtrahend_i = '0;
    #1;
    chk("reset_ready", ready_o, 1);
    chk("reset_valid", valid_o, 0);
    chk("reset_diff", diff_o, 0);
    chk("reset_borrow", borrow_o, 0);
`ifdef SUB_SEQ_OVERFLOW_EN
    chk("reset_overflow", overflow_o, 0);
`endif
    #20;
    @(negedge clk);
    rst_ni = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) begin
      accept(vt[i].a, vt[i].b, vt[i].bin,
             mk(vt[i].d, vt[i].bo, vt[i].ov));
      wait_valid($sformatf("vec%0d", i));
      consume($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      accept(ra, rb, rc, model(ra, rb, rc));
      wait_valid($sformatf("rnd%0d", i));
      consume($sformatf("rnd%0d", i));
    end

    ready_i = 1'b0;
    accept(16'h3333, 16'h1111, 1'b0, mk(16'h2222, 1'b0, 1'b0));
    wait_valid("hold");
    minuend_i    = 16'hDEAD;
    subtrahend_i = 16'hBEEF;
    borrow_i     = 1'b0;
    valid_i      = 1'b1;
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("hold%0d_diff", i), diff_o, e.d);
      chk($sformatf("hold%0d_borrow", i), borrow_o, e.bo);
      chk($sformatf("hold%0d_ready", i), ready_o, 0);
      chk($sformatf("hold%0d_valid", i), valid_o, 1);
    end
    consume("hold");
    accept(16'hDEAD, 16'hBEEF, 1'b0, model(16'hDEAD, 16'hBEEF, 1'b0));
    wait_valid("after_hold");
    consume("after_hold");

    accept(16'h4321, 16'h1234, 1'b0, model(16'h4321, 16'h1234, 1'b0));
    tick;
    rst_ni = 1'b0;
    #1;
    chk("abort_valid", valid_o, 0);
    chk("abort_ready", ready_o, 1);
    chk("abort_diff", diff_o, 0);
    chk("abort_borrow", borrow_o, 0);
    sb.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (valid_o) seen++;
    end
    chk("abort_no_result", seen, 0);
    accept(16'h00FF, 16'h000F, 1'b0, mk(16'h00F0, 1'b0, 1'b0));
    wait_valid("post_abort");
    consume("post_abort");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
